ram_stream_rd: RTL and testbench

//  Read-side sequencer for the lab3 dual-port RAM (registered read, 1-cycle latency, no read enable).
//  On a start pulse, reads `len` consecutive words from `base_addr` and emits them on a valid/ready stream.

---
 rtl/ram_stream_pkg.sv | 20 ++
 rtl/stream_fifo.sv | 65 ++++++
 rtl/ram_stream_rd.sv | 122 ++++++++++++
 tb/tb_ram_stream_rd.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_pkg.sv
// Shared types and sizing helpers for the RAM stream read sequencer.
package ram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  // Occupancy counter width: must represent 0..depth inclusive.
  localparam int FIFO_CNT_W = $clog2(DEFAULT_FIFO_DEPTH + 1);

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO holding {last, data}; head is presented combinationally.
module stream_fifo
  import ram_stream_pkg::*;
#(
  parameter  int W     = 33,
  parameter  int DEPTH = 4,
  localparam int CW    = fifo_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          valid,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (count_q != '0);
  assign head   = mem_q[rd_ptr_q];
  assign valid  = (count_q != '0);
  assign count  = count_q;

  // Storage array: written on push, no reset needed since valid gates the head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      count_q <= count_q + CW'(push) - CW'(do_pop);
    end
  end

  // The issuing side's credit check must keep pushes out of a full FIFO.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
                                !(push && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/ram_stream_rd.sv
// Read-side sequencer: streams len words from a 1-cycle-latency RAM onto valid/ready.
module ram_stream_rd
  import ram_stream_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last
);

  localparam int CW = fifo_cnt_w(FIFO_DEPTH);

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] rd_addr_q;
  logic [AW:0]   remaining_q;
  logic          inflight_q;
  logic          inflight_last_q;

  logic [CW:0]   occupancy;
  logic          issue;
  logic          last_issue;
  logic [DW:0]   fifo_head;
  logic          fifo_valid;
  logic [CW-1:0] fifo_count;
  logic          pop;

  // Credit counts the in-flight read but not a same-cycle pop.
  assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign issue      = (state_q == RUN) && (occupancy < (CW + 1)'(FIFO_DEPTH));
  assign last_issue = issue && (remaining_q == (AW + 1)'(1));

  assign pop     = fifo_valid && m_ready;
  assign m_valid = fifo_valid;
  assign m_data  = fifo_head[DW-1:0];
  assign m_last  = fifo_valid && fifo_head[DW];
  assign rd_addr = rd_addr_q;

  stream_fifo #(
    .W     (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({inflight_last_q, rd_data}),
    .pop       (pop),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  // State, address/remaining counters and the in-flight read tracker.
  // rd_addr is not advanced on the final issue so it holds the last address read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      rd_addr_q       <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      if ((state_q == IDLE) && start && (len != '0)) begin
        rd_addr_q   <= base_addr;
        remaining_q <= len;
      end else if (issue) begin
        remaining_q <= remaining_q - 1'b1;
        if (!last_issue) begin
          rd_addr_q <= rd_addr_q + 1'b1;
        end
      end
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!inflight_q && pop && fifo_head[DW]) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_stream_rd.sv
// Scoreboard bench for ram_stream_rd against a behavioural 1-cycle-latency RAM.
module tb_ram_stream_rd;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  always #5 clk = ~clk;

  ram_stream_rd #(
    .AW         (AW),
    .DW         (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  // RAM model: registered read, no enable.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int vectors     = 0;
  int miscompares = 0;

  logic [DW:0]   sb [$];
  logic [AW-1:0] addr_log [$];
  int            sample_idx = 0;
  int            start_idx;
  int            beat_cnt;
  int            first_beat;
  int            last_beat;
  bit            done_next;
  bit            done_arm;
  bit            saw_done;
  bit            prev_stalled;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  bit            log_addr;
  logic [AW-1:0] prev_rd_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called #1 after inputs are driven at the negedge: a handshake seen here
  // completes at the following posedge.
  task automatic sample();
    bit          due;
    logic [DW:0] e;
    sample_idx++;
    due       = done_next;
    done_next = done_arm;
    done_arm  = 1'b0;
    if (due || done) chk("done_pulse", done, due);
    if (done) saw_done = 1'b1;
    if (prev_stalled) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_data);
      chk("stall_last", m_last, prev_last);
    end
    prev_stalled = m_valid && !m_ready;
    prev_data    = m_data;
    prev_last    = m_last;
    if (log_addr && (rd_addr !== prev_rd_addr)) addr_log.push_back(rd_addr);
    prev_rd_addr = rd_addr;
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("extra_beat", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("beat_data", m_data, e[DW-1:0]);
        chk("beat_last", m_last, e[DW]);
      end
      if (beat_cnt == 0) first_beat = sample_idx;
      last_beat = sample_idx;
      beat_cnt++;
      if (m_last) done_next = 1'b1;
    end
  endtask

  task automatic tick();
    #1;
    sample();
    @(negedge clk);
  endtask

  function automatic logic ready_pat(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic do_reset();
    rst     = 1'b1;
    start   = 1'b0;
    m_ready = 1'b0;
    tick();
    sb.delete();
    done_next    = 1'b0;
    done_arm     = 1'b0;
    prev_stalled = 1'b0;
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_last", m_last, 0);
    chk("rst_addr", rd_addr, 0);
    rst = 1'b0;
  endtask

  // Issue one transfer and run to done; mode 3 re-pulses start mid-transfer.
  task automatic run_xfer(input logic [AW-1:0] b, input int l, input int mode);
    logic [AW-1:0] a;
    for (int i = 0; i < l; i++) begin
      a = b + AW'(i);
      sb.push_back({(i == l - 1), mem[a]});
    end
    beat_cnt  = 0;
    saw_done  = 1'b0;
    start     = 1'b1;
    base_addr = b;
    len       = (AW + 1)'(l);
    if (l == 0) done_arm = 1'b1;
    m_ready   = ready_pat(mode, 0);
    tick();
    start_idx = sample_idx;
    start     = 1'b0;
    #1;
    chk("busy_after_start", busy, (l != 0));
    for (int c = 1; c < 200 && !saw_done; c++) begin
      m_ready = ready_pat(mode, c);
      if (mode == 3) begin
        start     = (c == 2);
        base_addr = 8'h40;
        len       = 9'd2;
      end
      tick();
    end
    start = 1'b0;
    if (!saw_done) chk("timeout_done", 0, 1);
    chk("sb_drained", sb.size(), 0);
    chk("beat_count", beat_cnt, l);
    #1;
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] exp_addr [4];
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = DW'(32'hA0 + i);
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b0;
    log_addr  = 1'b0;
    @(negedge clk);
    do_reset();

    // 1: full-rate transfer
    run_xfer(8'h10, 4, 0);
    chk("first_beat_latency", first_beat - start_idx, 3);
    chk("consecutive_beats", last_beat - first_beat, 3);

    // 2: alternating backpressure
    run_xfer(8'h10, 4, 1);

    // 3: address wrap
    addr_log.delete();
    prev_rd_addr = rd_addr;
    log_addr     = 1'b1;
    run_xfer(8'hFE, 4, 0);
    log_addr = 1'b0;
    exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    chk("wrap_addr_count", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("wrap_addr", addr_log[i], exp_addr[i]);

    // 4: zero-length transfer
    run_xfer(8'h22, 0, 0);

    // 5: reset mid-transfer after two beats
    for (int i = 0; i < 8; i++) sb.push_back({(i == 7), mem[8'h30 + i]});
    beat_cnt  = 0;
    start     = 1'b1;
    base_addr = 8'h30;
    len       = 9'd8;
    m_ready   = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50 && beat_cnt < 2; c++) tick();
    chk("abort_beats", beat_cnt, 2);
    m_ready = 1'b0;
    tick();
    tick();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("abort_valid", m_valid, 0);
      chk("abort_busy", busy, 0);
    end
    run_xfer(8'h10, 4, 0);

    // 6: start re-pulsed while busy is ignored
    run_xfer(8'h20, 4, 3);

    // extra: random backpressure, longer transfer
    run_xfer(8'h80, 12, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
